debounced_pulser_n: RTL and testbench
=====================================

DEBOUNCED_PULSER_N -- requirements
Module: debounced_pulser_n

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent push-button channels (1..16).
REQ-002 SHALL have parameter DB_CYCLES, default 500000: stable-sample cycles required to accept a level change (>=1).
REQ-003 SHALL have parameter REPEAT_EN, default 0: 1 enables auto-repeat on held buttons.
REQ-004 SHALL have parameter REPEAT_DELAY, default 25000000: cycles from press pulse to first repeat pulse (>=2).
REQ-005 SHALL have parameter REPEAT_PERIOD, default 5000000: cycles between subsequent repeat pulses (>=1).
REQ-006 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port btn_in  input  N_CH  raw asynchronous button levels, 1 = pressed.
REQ-009 SHALL have port ch_en  input  N_CH  per-channel pulse enable.
REQ-010 SHALL have port btn_level  output  N_CH  debounced level per channel.
REQ-011 SHALL have port press_pulse  output  N_CH  one-cycle press/repeat strobe per channel.
REQ-012 SHALL have port release_pulse  output  N_CH  one-cycle release strobe per channel.
REQ-013 SHALL have port any_pulse  output  1  OR of all press_pulse and release_pulse bits, same cycle.

Function
REQ-014 SHALL pass each btn_in bit through a two-flop synchronizer (s1, s2) before any other use.
REQ-015 SHALL keep per channel a debounce counter, width clog2(DB_CYCLES+1); counter cleared on any edge where s2 equals btn_level.
REQ-016 SHALL, on an edge where s2 differs from btn_level and counter == DB_CYCLES-1, load btn_level with s2 and clear the counter; otherwise increment.
REQ-017 SHALL therefore change btn_level exactly DB_CYCLES+1 edges after btn_in is first sampled at its new level, provided it stays there; any glitch shorter than that restarts the count.
REQ-018 SHALL register press_pulse[i] high for exactly one cycle on the edge after btn_level[i] rises (btn_level & ~btn_level_d), i.e. DB_CYCLES+2 edges after the sampling edge.
REQ-019 SHALL register release_pulse[i] high for one cycle on the edge after btn_level[i] falls, same latency.
REQ-020 SHALL, when REPEAT_EN=1, load a per-channel repeat counter with REPEAT_DELAY on the press-pulse edge.
REQ-021 SHALL, on each following edge with btn_level high: if counter == 1 assert press_pulse and reload REPEAT_PERIOD, else decrement; first repeat at press edge + REPEAT_DELAY, then every REPEAT_PERIOD.
REQ-022 SHALL clear the repeat counter when btn_level is low; no repeat pulse after or during the release-pulse cycle.
REQ-023 SHALL, when REPEAT_EN=0, generate exactly one press_pulse per accepted press regardless of hold time.
REQ-024 SHALL gate press_pulse[i] and release_pulse[i] with ch_en[i] sampled at the pulse edge; synchronizer, debounce, btn_level and repeat counter run regardless of ch_en.
REQ-025 SHALL treat channels fully independently; simultaneous events on several channels produce simultaneous pulses.
REQ-026 SHALL never assert press_pulse and release_pulse on the same channel in the same cycle.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, clear s1, s2, btn_level, btn_level_d, all counters and all outputs to 0.
REQ-028 SHALL, after rst deasserts with btn_in held high, treat it as a new press (press_pulse after DB_CYCLES+2 edges).
REQ-029 SHALL abort any in-progress debounce or repeat sequence when rst is asserted mid-operation; no pulse in the cycle following reset.

Verification (N_CH=4, DB_CYCLES=4, REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-030 SHALL cover: btn_in[0] 0->1 sampled at edge k, held -> btn_level[0]=1 after edge k+5, press_pulse[0]=1 only in cycle after edge k+6, any_pulse matches.
REQ-031 SHALL cover: btn_in[1] high for 3 cycles then low -> btn_level[1], press_pulse[1], release_pulse[1] stay 0.
REQ-032 SHALL cover: btn_in[2] held 40 cycles, press at edge p -> press_pulse[2] at p, p+10, p+15, p+20, ...; release_pulse[2] once, 6 edges after btn_in drop is sampled.
REQ-033 SHALL cover: ch_en[3]=0 during press -> btn_level[3]=1, press_pulse[3]=0; ch_en[3]=1 before release -> release_pulse[3]=1.
REQ-034 SHALL cover: channels 0 and 1 pressed in same cycle -> press_pulse=4'b0011 in one cycle.
REQ-035 SHALL cover: rst=1 for one edge midway through repeat hold -> all outputs 0, fresh press_pulse 6 edges after rst drops.

Source files
------------

// File: rtl/debounced_pulser_n.sv
// -----------------------------------------------------------------------------
// debounced_pulser_n
//
// Purpose:
//   N_CH independent push-button conditioners. Each raw button level is
//   synchronised through two flops, debounced by requiring DB_CYCLES
//   consecutive disagreeing samples before the accepted level changes, and
//   turned into one-cycle press / release strobes. With REPEAT_EN=1 a held
//   button also produces repeat press strobes: the first REPEAT_DELAY cycles
//   after the press strobe, then one every REPEAT_PERIOD cycles.
//
// Ports:
//   clk           in   system clock, all state updates on the rising edge
//   rst           in   synchronous active-high reset
//   btn_in        in   [N_CH] raw asynchronous button levels, 1 = pressed
//   ch_en         in   [N_CH] per-channel strobe enable (gates strobes only)
//   btn_level     out  [N_CH] debounced level per channel
//   press_pulse   out  [N_CH] one-cycle press / repeat strobe
//   release_pulse out  [N_CH] one-cycle release strobe
//   any_pulse     out  OR of all press and release strobes, same cycle
// -----------------------------------------------------------------------------
module debounced_pulser_n #(
  parameter int N_CH          = 4,
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] ch_en,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic            any_pulse
);

  localparam int DB_W    = $clog2(DB_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE     = DB_W'(1);
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_DELAY  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PERIOD = RPT_W'(REPEAT_PERIOD);

  // Synchroniser, debounce and edge-detect state
  logic [N_CH-1:0]  r_s1;
  logic [N_CH-1:0]  r_s2;
  logic [N_CH-1:0]  r_level;
  logic [N_CH-1:0]  r_level_d;
  logic [DB_W-1:0]  r_db_cnt  [N_CH];
  logic [RPT_W-1:0] r_rpt_cnt [N_CH];

  // Registered outputs
  logic [N_CH-1:0]  r_press;
  logic [N_CH-1:0]  r_release;
  logic             r_any;

  // Next-cycle strobe values
  logic [N_CH-1:0]  w_rise;
  logic [N_CH-1:0]  w_fall;
  logic [N_CH-1:0]  w_rpt_hit;
  logic [N_CH-1:0]  w_press;
  logic [N_CH-1:0]  w_release;

  // NOTE: every signal written in always_comb gets a default at the top so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    w_rise    = r_level & ~r_level_d;
    w_fall    = ~r_level & r_level_d;
    w_rpt_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      // A repeat fires while the level is high and the countdown is on its
      // last cycle. The rise edge itself is the original press strobe.
      if ((REPEAT_EN != 0) && r_level[i] && !w_rise[i] && (r_rpt_cnt[i] == RPT_ONE)) begin
        w_rpt_hit[i] = 1'b1;
      end
    end
    // ch_en only masks the strobes; all tracking state runs regardless.
    w_press   = (w_rise | w_rpt_hit) & ch_en;
    w_release = w_fall & ch_en;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values and the two-flop synchroniser really is two flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_level   <= '0;
      r_level_d <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_any     <= 1'b0;
      // NOTE: the counter arrays are reset too; they are per-channel control
      // state, not data storage, and a stale count would leak across reset.
      for (int i = 0; i < N_CH; i++) begin
        r_db_cnt[i]  <= '0;
        r_rpt_cnt[i] <= '0;
      end
    end else begin
      r_s1      <= btn_in;
      r_s2      <= r_s1;
      r_level_d <= r_level;
      r_press   <= w_press;
      r_release <= w_release;
      r_any     <= |{w_press, w_release};

      for (int i = 0; i < N_CH; i++) begin
        // Debounce: count consecutive samples that disagree with the accepted
        // level; any agreeing sample restarts the count.
        if (r_s2[i] == r_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_level[i]  <= r_s2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_ONE;
        end

        // Auto-repeat countdown, idle (zero) whenever the level is low.
        if (REPEAT_EN == 0 || !r_level[i]) begin
          r_rpt_cnt[i] <= '0;
        end else if (w_rise[i]) begin
          r_rpt_cnt[i] <= RPT_DELAY;
        end else if (r_rpt_cnt[i] == RPT_ONE) begin
          r_rpt_cnt[i] <= RPT_PERIOD;
        end else if (r_rpt_cnt[i] != '0) begin
          r_rpt_cnt[i] <= r_rpt_cnt[i] - RPT_ONE;
        end
      end
    end
  end

  assign btn_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign any_pulse     = r_any;

endmodule

// File: tb/tb_debounced_pulser_n.sv
// -----------------------------------------------------------------------------
// tb_debounced_pulser_n
//
// Purpose:
//   Self-checking bench for debounced_pulser_n with N_CH=4, DB_CYCLES=4,
//   REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=5. A behavioural model
//   predicts every output each cycle; directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_debounced_pulser_n;

  localparam int NC = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic          clk;
  logic          rst;
  logic [NC-1:0] btn_in;
  logic [NC-1:0] ch_en;
  logic [NC-1:0] btn_level;
  logic [NC-1:0] press_pulse;
  logic [NC-1:0] release_pulse;
  logic          any_pulse;

  int n_vec;
  int n_err;

  debounced_pulser_n #(
    .N_CH          (NC),
    .DB_CYCLES     (DB),
    .REPEAT_EN     (1),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .ch_en         (ch_en),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .any_pulse     (any_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. The accepted level flips once the last DB synchronised
  // samples (all taken since the previous flip or reset) disagree with it.
  // Press strobes come from the rise and from arithmetic on the time elapsed
  // since the press strobe; release strobes from the fall.
  // ---------------------------------------------------------------------------
  int          cyc;
  bit          m_valid;
  bit          m_s1    [NC];
  bit          m_s2    [NC];
  bit          m_lvl   [NC];
  bit          m_lvl_d [NC];
  logic [DB-1:0] m_hist [NC];
  int          m_age   [NC];
  int          m_p     [NC];
  logic [NC-1:0] e_level, e_press, e_release;
  logic          e_any;

  always @(posedge clk) begin
    bit old_lvl, old_d, prs, rel, flip;
    int dt;
    cyc++;
    if (rst) begin
      for (int ch = 0; ch < NC; ch++) begin
        m_s1[ch] = 0; m_s2[ch] = 0; m_lvl[ch] = 0; m_lvl_d[ch] = 0;
        m_hist[ch] = '0; m_age[ch] = 0; m_p[ch] = -1;
      end
      e_level = '0; e_press = '0; e_release = '0; e_any = 1'b0;
      m_valid = 1'b1;
    end else begin
      for (int ch = 0; ch < NC; ch++) begin
        old_lvl = m_lvl[ch];
        old_d   = m_lvl_d[ch];
        prs     = 0;
        rel     = 0;
        if (old_lvl && !old_d) begin
          prs = 1;
          m_p[ch] = cyc;
        end else if (old_lvl && m_p[ch] >= 0) begin
          dt = cyc - m_p[ch];
          if (dt == RD || (dt > RD && (dt - RD) % RP == 0)) prs = 1;
        end
        if (!old_lvl && old_d) rel = 1;
        if (!old_lvl) m_p[ch] = -1;

        m_hist[ch] = {m_hist[ch][DB-2:0], m_s2[ch]};
        m_age[ch]++;
        flip = (m_age[ch] >= DB) && (m_hist[ch] == {DB{!old_lvl}});
        m_lvl_d[ch] = old_lvl;
        if (flip) begin
          m_lvl[ch] = !old_lvl;
          m_age[ch] = 0;
        end
        m_s2[ch] = m_s1[ch];
        m_s1[ch] = btn_in[ch];

        e_level[ch]   = m_lvl[ch];
        e_press[ch]   = prs & ch_en[ch];
        e_release[ch] = rel & ch_en[ch];
      end
      e_any = |{e_press, e_release};
    end
  end

  // Single compare process, on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_btn_level",     16'(btn_level),     16'(e_level));
      check("model_press_pulse",   16'(press_pulse),   16'(e_press));
      check("model_release_pulse", 16'(release_pulse), 16'(e_release));
      check("model_any_pulse",     16'(any_pulse),     16'(e_any));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  int cnt_press [NC];
  int cnt_rel   [NC];

  task automatic clear_counts();
    for (int ch = 0; ch < NC; ch++) begin
      cnt_press[ch] = 0;
      cnt_rel[ch]   = 0;
    end
  endtask

  // Advance one edge, then look at the outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int ch = 0; ch < NC; ch++) begin
      if (press_pulse[ch])   cnt_press[ch]++;
      if (release_pulse[ch]) cnt_rel[ch]++;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int first_idx, second_idx, rel_idx, n_press2;
    n_vec   = 0;
    n_err   = 0;
    cyc     = 0;
    m_valid = 1'b0;
    rst     = 1'b1;
    btn_in  = '0;
    ch_en   = 4'hF;
    clear_counts();

    // Reset state
    ticks(3);
    check("reset_level",   16'(btn_level),     16'h0);
    check("reset_press",   16'(press_pulse),   16'h0);
    check("reset_release", 16'(release_pulse), 16'h0);
    check("reset_any",     16'(any_pulse),     16'h0);
    rst = 1'b0;
    ticks(3);

    // Single press on channel 0: sampled at edge k = next edge.
    btn_in[0] = 1'b1;
    ticks(5);                                  // edge k+4
    check("t1_level_k4", 16'(btn_level[0]), 16'h0);
    tick();                                    // edge k+5
    check("t1_level_k5", 16'(btn_level[0]), 16'h1);
    check("t1_press_k5", 16'(press_pulse),  16'h0);
    tick();                                    // edge k+6
    check("t1_press_k6", 16'(press_pulse),  16'h1);
    check("t1_any_k6",   16'(any_pulse),    16'h1);
    tick();                                    // edge k+7
    check("t1_press_k7", 16'(press_pulse),  16'h0);
    btn_in[0] = 1'b0;
    clear_counts();
    ticks(20);
    check("t1_release_count", 16'(cnt_rel[0]),   16'd1);
    check("t1_repeat_none",   16'(cnt_press[0]), 16'd0);

    // Short glitch on channel 1 (3 samples): rejected.
    clear_counts();
    btn_in[1] = 1'b1;
    ticks(3);
    btn_in[1] = 1'b0;
    ticks(12);
    check("t2_level",   16'(btn_level[1]), 16'h0);
    check("t2_press",   16'(cnt_press[1]), 16'd0);
    check("t2_release", 16'(cnt_rel[1]),   16'd0);

    // Exactly DB_CYCLES samples high on channel 1: accepted.
    clear_counts();
    btn_in[1] = 1'b1;
    ticks(4);
    btn_in[1] = 1'b0;
    ticks(20);
    check("t2b_press",   16'(cnt_press[1]), 16'd1);
    check("t2b_release", 16'(cnt_rel[1]),   16'd1);

    // Auto-repeat on channel 2, held 40 samples.
    first_idx = 0; second_idx = 0; rel_idx = 0; n_press2 = 0;
    btn_in[2] = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (press_pulse[2]) begin
        n_press2++;
        if (n_press2 == 1) first_idx = i;
        if (n_press2 == 2) second_idx = i;
      end
      if (release_pulse[2]) rel_idx = i;
      if (i == 40) btn_in[2] = 1'b0;
    end
    check("t3_press_idx",   16'(first_idx),  16'd7);
    check("t3_repeat1_idx", 16'(second_idx), 16'd17);
    check("t3_press_count", 16'(n_press2),   16'd7);
    check("t3_release_idx", 16'(rel_idx),    16'd47);

    // Channel 3 pressed while disabled, released while enabled.
    clear_counts();
    ch_en     = 4'b0111;
    btn_in[3] = 1'b1;
    ticks(8);
    check("t4_level", 16'(btn_level[3]), 16'h1);
    ch_en     = 4'hF;
    btn_in[3] = 1'b0;
    ticks(15);
    check("t4_press",   16'(cnt_press[3]), 16'd0);
    check("t4_release", 16'(cnt_rel[3]),   16'd1);

    // Channels 0 and 1 pressed together.
    btn_in[1:0] = 2'b11;
    ticks(7);
    check("t5_press", 16'(press_pulse), 16'h3);
    check("t5_any",   16'(any_pulse),   16'h1);
    btn_in[1:0] = 2'b00;
    ticks(7);
    check("t5_release", 16'(release_pulse), 16'h3);
    ticks(10);

    // Reset in the middle of a repeat hold on channel 2.
    btn_in[2] = 1'b1;
    ticks(20);
    rst = 1'b1;
    tick();
    check("t6_rst_level",   16'(btn_level),     16'h0);
    check("t6_rst_press",   16'(press_pulse),   16'h0);
    check("t6_rst_release", 16'(release_pulse), 16'h0);
    check("t6_rst_any",     16'(any_pulse),     16'h0);
    rst = 1'b0;
    ticks(6);
    check("t6_level_r6", 16'(btn_level[2]), 16'h1);
    check("t6_press_r6", 16'(press_pulse),  16'h0);
    tick();
    check("t6_press_r7", 16'(press_pulse),  16'h4);
    btn_in[2] = 1'b0;
    ticks(25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
